// File: rtl/logic_vector_sweeper.sv
// Board-level self-test sequencer: walks all eight {A,B,C} vectors through the
// 3-in/3-out logic unit and checks X=A, Y=~A, Z=B&C after a settle delay.
module logic_vector_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       step_mode,
  input  logic       step,
  output logic       a_o,
  output logic       b_o,
  output logic       c_o,
  input  logic       x_i,
  input  logic       y_i,
  input  logic       z_i,
  output logic [2:0] vec_o,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_mask
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    WAIT_STEP,
    DONE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       vec_q;
  logic             stepm_q;
  logic             pass_q;
  logic [3:0]       err_q;
  logic [7:0]       fail_q;

  logic [2:0]       golden_d;
  logic             mismatch_d;
  logic [3:0]       err_d;
  logic [7:0]       fail_d;

  // Result bookkeeping for the vector currently being sampled; only
  // committed to the registers while in SAMPLE.
  always_comb begin
    golden_d   = {vec_q[2], ~vec_q[2], vec_q[1] & vec_q[0]};
    mismatch_d = ({x_i, y_i, z_i} != golden_d);
    err_d      = err_q + {3'd0, mismatch_d};
    fail_d     = fail_q | ({7'd0, mismatch_d} << vec_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vec_q   <= 3'd0;
      stepm_q <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 4'd0;
      fail_q  <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          vec_q <= 3'd0;
          if (start) begin
            state_q <= SETTLE;
            cnt_q   <= '0;
            stepm_q <= step_mode;
            pass_q  <= 1'b0;
            err_q   <= 4'd0;
            fail_q  <= 8'd0;
          end
        end
        SETTLE: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        SAMPLE: begin
          err_q  <= err_d;
          fail_q <= fail_d;
          cnt_q  <= '0;
          if (vec_q == 3'd7) begin
            // pass must already include the final vector's result
            state_q <= DONE;
            pass_q  <= (err_d == 4'd0);
          end else if (!stepm_q) begin
            state_q <= SETTLE;
            vec_q   <= vec_q + 3'd1;
          end else begin
            state_q <= WAIT_STEP;
          end
        end
        WAIT_STEP: begin
          if (step) begin
            state_q <= SETTLE;
            vec_q   <= vec_q + 3'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          vec_q   <= 3'd0;
        end
        default: begin
          state_q <= IDLE;
          vec_q   <= 3'd0;
        end
      endcase
    end
  end

  assign vec_o     = vec_q;
  assign a_o       = vec_q[2];
  assign b_o       = vec_q[1];
  assign c_o       = vec_q[0];
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_mask = fail_q;

endmodule

// File: tb/tb_logic_vector_sweeper.sv
// Bench for logic_vector_sweeper: two instances (settle 4 and settle 1) share
// stimulus and a faultable logic unit; a timing-based model is checked every cycle.
module tb_logic_vector_sweeper;

  logic       clk = 1'b0;
  logic       reset, start, step_mode, step;
  int         fault;  // 0 good unit, 1 Z stuck at 0, 2 Y stuck at 1

  logic       a0, b0, c0, x0, y0, z0, busy0, done0, pass0;
  logic [2:0] vec0;
  logic [3:0] err0;
  logic [7:0] fm0;
  logic       a1, b1, c1, x1, y1, z1, busy1, done1, pass1;
  logic [2:0] vec1;
  logic [3:0] err1;
  logic [7:0] fm1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t0 = 0;
  int ndone0 = 0;

  function automatic logic [2:0] unit_out(input logic [2:0] abc, input int f);
    logic x, y, z;
    x = abc[2];
    y = !abc[2];
    z = abc[1] && abc[0];
    if (f == 1) z = 1'b0;
    if (f == 2) y = 1'b1;
    return {x, y, z};
  endfunction

  function automatic logic [2:0] golden(input int v);
    logic [2:0] b;
    b = v[2:0];
    return {b[2], ~b[2], b[1] & b[0]};
  endfunction

  assign {x0, y0, z0} = unit_out({a0, b0, c0}, fault);
  assign {x1, y1, z1} = unit_out({a1, b1, c1}, fault);

  logic_vector_sweeper #(.SETTLE_CYCLES(4)) dut0 (
    .clk(clk), .reset(reset), .start(start), .step_mode(step_mode), .step(step),
    .a_o(a0), .b_o(b0), .c_o(c0), .x_i(x0), .y_i(y0), .z_i(z0),
    .vec_o(vec0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_mask(fm0)
  );

  logic_vector_sweeper #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .step_mode(step_mode), .step(step),
    .a_o(a1), .b_o(b1), .c_o(c1), .x_i(x1), .y_i(y1), .z_i(z1),
    .vec_o(vec1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_mask(fm1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors < 60) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: each vector is S settle cycles (pos 0..S-1) plus one sample cycle (pos S).
  int          S[2] = '{4, 1};
  bit          m_busy[2], m_done[2], m_wait[2], m_stepm[2], m_pass[2];
  int          m_vec[2], m_pos[2], m_err[2];
  logic [7:0]  m_fail[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_busy[i] = 0; m_done[i] = 0; m_wait[i] = 0; m_stepm[i] = 0; m_pass[i] = 0;
        m_vec[i] = 0; m_pos[i] = 0; m_err[i] = 0; m_fail[i] = 8'h00;
      end else if (m_done[i]) begin
        m_done[i] = 0; m_busy[i] = 0; m_vec[i] = 0;
      end else if (!m_busy[i]) begin
        if (start) begin
          m_busy[i] = 1; m_vec[i] = 0; m_pos[i] = 0; m_wait[i] = 0;
          m_err[i] = 0; m_fail[i] = 8'h00; m_pass[i] = 0; m_stepm[i] = step_mode;
        end
      end else if (m_wait[i]) begin
        if (step) begin
          m_vec[i]++; m_pos[i] = 0; m_wait[i] = 0;
        end
      end else if (m_pos[i] < S[i]) begin
        m_pos[i]++;
      end else begin
        if (unit_out(m_vec[i][2:0], fault) != golden(m_vec[i])) begin
          m_err[i]++;
          m_fail[i][m_vec[i]] = 1'b1;
        end
        if (m_vec[i] == 7) begin
          m_done[i] = 1; m_pass[i] = (m_err[i] == 0);
        end else if (m_stepm[i]) begin
          m_wait[i] = 1;
        end else begin
          m_vec[i]++; m_pos[i] = 0;
        end
      end
    end
  end

  task automatic cmp(input int i, input logic [2:0] v, input logic a, input logic b,
                     input logic c, input logic bz, input logic dn, input logic ps,
                     input logic [3:0] e, input logic [7:0] fm);
    string p;
    p = (i == 0) ? "s4" : "s1";
    chk({p, ".vec_o"}, v, m_vec[i]);
    chk({p, ".abc"}, {a, b, c}, m_vec[i]);
    chk({p, ".busy"}, bz, m_busy[i]);
    chk({p, ".done"}, dn, m_done[i]);
    chk({p, ".pass"}, ps, m_pass[i]);
    chk({p, ".err_count"}, e, m_err[i]);
    chk({p, ".fail_mask"}, fm, m_fail[i]);
  endtask

  always @(negedge clk) begin
    cmp(0, vec0, a0, b0, c0, busy0, done0, pass0, err0, fm0);
    cmp(1, vec1, a1, b1, c1, busy1, done1, pass1, err1, fm1);
    if (done0 === 1'b1) ndone0++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit sm);
    start = 1'b1;
    step_mode = sm;
    tick();
    t0 = cyc;
    start = 1'b0;
  endtask

  // ev_kind: 0 none, 1 extra start pulse at ev_vec, 2 reset pulse at ev_vec
  task automatic run_auto(input int f, input int ev_kind, input int ev_vec,
                          output int dd0, output int dd1);
    bit ev_done, rst_pend;
    fault = f;
    ev_done = 0;
    rst_pend = 0;
    pulse_start(1'b0);
    dd0 = -1;
    dd1 = -1;
    for (int k = 0; k < 70 && dd0 < 0; k++) begin
      start = 1'b0;
      reset = 1'b0;
      if (rst_pend) begin
        chk("rst_mid.busy", busy0, 1'b0);
        chk("rst_mid.vec", vec0, 3'd0);
        chk("rst_mid.err", err0, 4'd0);
        chk("rst_mid.mask", fm0, 8'h00);
        chk("rst_mid.pass", pass0, 1'b0);
        rst_pend = 0;
      end
      if (done1 === 1'b1 && dd1 < 0) dd1 = cyc - t0 + 1;
      if (done0 === 1'b1) dd0 = cyc - t0 + 1;
      if (ev_kind != 0 && !ev_done && vec0 === ev_vec[2:0]) begin
        if (ev_kind == 1) start = 1'b1;
        else begin
          reset = 1'b1;
          rst_pend = 1;
        end
        ev_done = 1;
      end
      if (dd0 < 0) tick();
    end
    start = 1'b0;
    reset = 1'b0;
    tick();
    if (ev_kind != 2) chk("done_seen", (dd0 >= 0), 1'b1);
  endtask

  int d0, d1, nd;

  initial begin
    reset = 1'b1; start = 1'b0; step_mode = 1'b0; step = 1'b0; fault = 0;
    // Reset held three cycles, with start asserted during one of them
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rst.busy", busy0, 1'b0);
    tick();
    chk("rst.busy2", busy0, 1'b0);
    reset = 1'b0;
    tick();
    chk("rst.vec", vec0, 3'd0);
    chk("rst.abc", {a0, b0, c0}, 3'd0);
    chk("rst.busy3", busy0, 1'b0);
    chk("rst.done", done0, 1'b0);
    chk("rst.pass", pass0, 1'b0);
    chk("rst.err", err0, 4'd0);
    chk("rst.mask", fm0, 8'h00);

    // Good unit, auto mode
    run_auto(0, 0, 0, d0, d1);
    chk("good.done_at", d0, 41);
    chk("good.done_at_s1", d1, 17);
    chk("good.busy_after", busy0, 1'b0);
    chk("good.pass", pass0, 1'b1);
    chk("good.err", err0, 4'd0);
    chk("good.mask", fm0, 8'h00);
    chk("good.pass_s1", pass1, 1'b1);

    // Z stuck at 0
    run_auto(1, 0, 0, d0, d1);
    chk("zs0.err", err0, 4'd2);
    chk("zs0.mask", fm0, 8'h88);
    chk("zs0.pass", pass0, 1'b0);
    chk("zs0.mask_s1", fm1, 8'h88);

    // Y stuck at 1
    run_auto(2, 0, 0, d0, d1);
    chk("ys1.err", err0, 4'd4);
    chk("ys1.mask", fm0, 8'hF0);
    chk("ys1.pass", pass0, 1'b0);

    // Step mode, good unit
    fault = 0;
    nd = ndone0;
    pulse_start(1'b1);
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    chk("step.hold_vec0", vec0, 3'd0);
    chk("step.busy", busy0, 1'b1);
    for (int j = 1; j <= 7; j++) begin
      if (j == 7) chk("step.no_early_done", ndone0, nd);
      step = 1'b1;
      tick();
      step = 1'b0;
      for (int k = 0; k < 7; k++) tick();
      if (j < 7) chk("step.vec", vec0, j);
    end
    chk("step.one_done", ndone0, nd + 1);
    chk("step.pass", pass0, 1'b1);
    chk("step.idle", busy0, 1'b0);

    // start pulsed again at vector 2 is ignored
    run_auto(0, 1, 2, d0, d1);
    chk("restart.done_at", d0, 41);
    chk("restart.pass", pass0, 1'b1);

    // reset at vector 5: no done afterwards
    nd = ndone0;
    run_auto(1, 2, 5, d0, d1);
    for (int k = 0; k < 20; k++) tick();
    chk("rst5.no_done", d0, -1);
    chk("rst5.done_count", ndone0, nd);
    chk("rst5.busy", busy0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
